regfile_dump_uart: RTL and testbench



---
 rtl/dbg_pkg.sv | 31 +++
 rtl/uart_tx_byte.sv | 73 +++++++
 rtl/regfile_dump_uart.sv | 120 ++++++++++++
 tb/tb_regfile_dump_uart.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared definitions for the register-file debug dump: UART frame shape,
// sync byte default, dump FSM states and a byte picker for 32-bit words.
package dbg_pkg;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SEL,
    CAP,
    SEND,
    NEXT,
    FIN
  } dump_state_e;

  // sel 0 picks the most significant byte so words go out big-endian.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
    case (sel)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. valid/ready: a byte is taken on any rising edge where
// valid && ready; ready is high only while the line idles between frames.
module uart_tx_byte
  import dbg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);

  logic                  active_q, active_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    ready    = !active_q;
    if (!active_q) begin
      if (valid) begin
        active_d = 1'b1;
        baud_d   = '0;
        bit_d    = '0;
        shift_d  = {{STOP_BITS{1'b1}}, data, 1'b0};
      end
    end else if (baud_q == BAUD_LAST) begin
      baud_d = '0;
      if (bit_q == BIT_LAST) begin
        active_d = 1'b0;
      end else begin
        bit_d   = bit_q + 1'b1;
        shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
      end
    end else begin
      baud_d = baud_q + 1'b1;
    end
    // Registered line: tx_q always equals what the next-cycle frame state implies.
    tx_d = active_d ? shift_d[0] : 1'b1;
  end

  assign tx = tx_q;

endmodule

// File: rtl/regfile_dump_uart.sv
// Walks the register file through a spare read port, snapshots each word and
// streams header + all words MSB byte first over UART 8N1 with 1-clk gaps.
module regfile_dump_uart
  import dbg_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         NUM_REGS     = 32,
  parameter logic [7:0] HEADER_BYTE  = HEADER_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  reg_select,
  input  logic [31:0] reg_data,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output dump_state_e dbg_state
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  dump_state_e state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [1:0]  byte_q, byte_d;
  logic [31:0] shadow_q, shadow_d;

  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .data (tx_data),
    .valid(tx_valid),
    .ready(tx_ready),
    .tx   (tx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      byte_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    shadow_d = shadow_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = HDR;
      end
      HDR: begin
        if (tx_ready) begin
          tx_valid = 1'b1;
          tx_data  = HEADER_BYTE;
          idx_d    = '0;
          state_d  = SEL;
        end
      end
      SEL: begin
        state_d = CAP;
      end
      CAP: begin
        // reg_select has been held on idx_q since SEL, so reg_data is settled.
        shadow_d = reg_data;
        byte_d   = '0;
        state_d  = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          tx_valid = 1'b1;
          tx_data  = word_byte(shadow_q, byte_q);
          if (byte_q == 2'd3) state_d = NEXT;
          else                byte_d  = byte_q + 2'd1;
        end
      end
      NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = SEL;
        end
      end
      FIN: begin
        // Wait out the last byte's stop bit before announcing completion.
        if (tx_ready) begin
          done    = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign reg_select = idx_q;
  assign busy       = (state_q != IDLE) && !done;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_regfile_dump_uart.sv
// Bench for regfile_dump_uart: models the register file, decodes the UART
// line against a byte queue and times busy/done for each dump.
module tb_regfile_dump_uart;
  import dbg_pkg::*;

  localparam int CPB        = 4;
  localparam int NREG       = 32;
  localparam int FRAME_CLKS = 10 * CPB + 1;
  localparam int DUMP_CLKS  = (1 + 4 * NREG) * FRAME_CLKS + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  reg_select;
  logic [31:0] reg_data;
  logic        tx, busy, done;
  dump_state_e dbg_state;

  logic [31:0] rf     [NREG];
  logic [31:0] exp_rf [NREG];
  logic [7:0]  exp_q[$];

  int n_checks   = 0;
  int n_fail     = 0;
  int done_count = 0;

  regfile_dump_uart #(
    .CLKS_PER_BIT(CPB),
    .NUM_REGS    (NREG),
    .HEADER_BYTE (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .reg_select(reg_select),
    .reg_data  (reg_data),
    .tx        (tx),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  assign reg_data = rf[reg_select];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_dump();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < NREG; i++) begin
      for (int b = 3; b >= 0; b--) exp_q.push_back(exp_rf[i][8*b +: 8]);
    end
  endtask

  always @(negedge clk) if (done === 1'b1) done_count++;

  // UART line monitor / scoreboard
  int         mon_s;
  logic [9:0] mon_bits;
  logic       mon_active = 1'b0;
  logic       mon_width_ok;
  int         gap_cnt = -1;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
      gap_cnt    = -1;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        if (gap_cnt >= 0) check("gap_clks", gap_cnt, 1);
        mon_active   = 1'b1;
        mon_s        = 1;
        mon_bits     = '0;
        mon_width_ok = 1'b1;
      end else if (gap_cnt >= 0) begin
        gap_cnt++;
      end
    end else begin
      if (mon_s % CPB == 0) mon_bits[mon_s / CPB] = tx;
      else if (tx !== mon_bits[mon_s / CPB]) mon_width_ok = 1'b0;
      mon_s++;
      if (mon_s == 10 * CPB) begin
        mon_active = 1'b0;
        check("bit_width", mon_width_ok, 1);
        check("stop_bit", mon_bits[9], 1);
        n_checks++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_frame: observed byte %h expected no frame", mon_bits[8:1]);
        end
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          check("rx_byte", mon_bits[8:1], exp_b);
        end
        gap_cnt = (exp_q.size() > 0) ? 0 : -1;
      end
    end
  end

  // driver: start a dump, optionally pulse start again, write the core
  // registers, or pulse reset at given cycle offsets from the start edge
  task automatic run_dump(input int pulse_at, input int wr_at, input int rst_at);
    bit busy_ok = 1'b1;
    int done_k  = -1;
    int dc0;
    @(negedge clk);
    dc0   = done_count;
    start = 1'b1;
    for (int k = 1; k <= DUMP_CLKS + 50; k++) begin
      @(negedge clk);
      if (k == 1 || k == pulse_at + 1) start = 1'b0;
      if (k == pulse_at) start = 1'b1;
      if (k == wr_at) begin
        rf[5] = 32'hDEADBEEF;
        rf[2] = 32'h12345678;
      end
      if (k == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        check("tx_on_reset", tx, 1);
        check("busy_on_reset", busy, 0);
        check("done_on_reset", done, 0);
        check("sel_on_reset", reg_select, 0);
        check("state_on_reset", dbg_state, IDLE);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        break;
      end
      if (done === 1'b1) begin
        done_k = k;
        check("busy_at_done", busy, 0);
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    if (rst_at == 0) begin
      check("busy_window", busy_ok, 1);
      check("done_cycle", done_k, DUMP_CLKS);
      repeat (5) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      check("done_pulses", done_count - dc0, 1);
      check("idle_after", dbg_state, IDLE);
    end
  endtask

  initial begin
    bit quiet_ok;
    int dc_before;

    for (int i = 0; i < NREG; i++) rf[i] = 32'h01020300 + i;

    // reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sel", reg_select, 0);
    check("rst_state", dbg_state, IDLE);
    #2 rst_n = 1'b1;

    // no start: line and status quiet for 1000 cycles
    quiet_ok = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) quiet_ok = 1'b0;
    end
    check("idle_quiet", quiet_ok, 1);
    check("idle_no_done", done_count, 0);

    // plain dump of preset values
    exp_rf = rf;
    push_dump();
    run_dump(0, 0, 0);

    // second start during register 10 is ignored
    push_dump();
    run_dump(2 + FRAME_CLKS * 42, 0, 0);

    // x5 written before capture shows up; x2 written after capture does not
    rf[5]  = 32'h0;
    exp_rf = rf;
    exp_rf[5] = 32'hDEADBEEF;
    push_dump();
    run_dump(0, 2 + FRAME_CLKS * 13 + 25, 0);
    rf[5] = 32'h01020305;
    rf[2] = 32'h01020302;

    // reset during register 20's second byte aborts the dump
    exp_rf = rf;
    push_dump();
    dc_before = done_count;
    run_dump(0, 0, 2 + FRAME_CLKS * 82 + 10);
    quiet_ok = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) quiet_ok = 1'b0;
    end
    check("abort_quiet", quiet_ok, 1);
    check("abort_no_done", done_count - dc_before, 0);

    // fresh dump after the abort is complete
    push_dump();
    run_dump(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
